// File: rtl/i2s_stereo_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_stereo_rx
// Purpose  : Stereo I2S / left-justified receiver. Delivers L/R pairs with a
//            one-cycle valid strobe and flags pairs with a mis-sized slot.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_stereo_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int MODE       = 0,
  parameter bit LEFT_LEVEL = 1'b0
) (
  input  logic                  bclk,
  input  logic                  reset,
  input  logic                  lrclk,
  input  logic                  sdata_in,
  output logic [DATA_WIDTH-1:0] o_left,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_valid,
  output logic                  o_frame_err
);

  localparam int                 c_CNT_W    = 6;
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(63);
  localparam logic [c_CNT_W-1:0] c_SLOT_LEN = c_CNT_W'(SLOT_WIDTH);
  localparam logic [c_CNT_W-1:0] c_DATA_LEN = c_CNT_W'(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0] c_MSB_POS  = c_CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] c_SYNC  = 2'd0;
  localparam logic [1:0] c_LEFT  = 2'd1;
  localparam logic [1:0] c_RIGHT = 2'd2;

  logic                  r_lrclk_d1;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  w_edge;
  logic                  w_enter_left;
  logic                  w_enter_right;
  logic                  w_len_bad;
  logic                  w_check_left;
  logic                  w_pair_ok;
  logic                  w_pair_err;
  logic                  r_left_err;
  logic                  r_pend_ok;
  logic                  r_pend_err;
  logic                  r_enter_right_d;
  logic [c_CNT_W-1:0]    w_k;
  logic                  w_cap_en;
  logic                  w_cap_left;
  logic                  w_cap;
  logic [DATA_WIDTH-1:0] w_bit_vec;
  logic [DATA_WIDTH-1:0] r_left_sr;
  logic [DATA_WIDTH-1:0] r_right_sr;
  logic [DATA_WIDTH-1:0] r_left_hold;

  assign w_edge        = (lrclk != r_lrclk_d1);
  assign w_enter_left  = w_edge && (lrclk == LEFT_LEVEL);
  assign w_enter_right = w_edge && (lrclk != LEFT_LEVEL);
  assign w_len_bad     = (r_cnt != c_SLOT_LEN);

  // In I2S the bit sampled on the edge still belongs to the slot that just
  // ended, so index and channel both lag by one bclk.
  generate
    if (MODE == 1) begin : g_left_justified
      assign w_k        = w_edge ? '0 : r_cnt;
      assign w_cap_en   = 1'b1;
      assign w_cap_left = (lrclk == LEFT_LEVEL);
    end else begin : g_i2s
      assign w_k        = r_cnt - c_ONE;
      assign w_cap_en   = (r_cnt != '0);
      assign w_cap_left = (r_lrclk_d1 == LEFT_LEVEL);
    end
  endgenerate

  assign w_cap     = w_cap_en && (w_k < c_DATA_LEN);
  assign w_bit_vec = {{(DATA_WIDTH-1){1'b0}}, sdata_in} << (c_MSB_POS - w_k);

  always_ff @(posedge bclk) begin
    if (reset) begin
      r_lrclk_d1 <= LEFT_LEVEL;
      r_cnt      <= '0;
    end else begin
      r_lrclk_d1 <= lrclk;
      if (w_edge)
        r_cnt <= c_ONE;
      else if (r_cnt != c_CNT_MAX)
        r_cnt <= r_cnt + c_ONE;
    end
  end

  // Bit 0 clears the register, so a short slot leaves its LSBs at zero.
  always_ff @(posedge bclk) begin
    if (reset) begin
      r_left_sr  <= '0;
      r_right_sr <= '0;
    end else if (w_cap) begin
      if (w_cap_left)
        r_left_sr <= (w_k == '0) ? w_bit_vec : (r_left_sr | w_bit_vec);
      else
        r_right_sr <= (w_k == '0) ? w_bit_vec : (r_right_sr | w_bit_vec);
    end
  end

  always_ff @(posedge bclk) begin
    if (reset)
      r_state <= c_SYNC;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_SYNC:  if (w_enter_left)  w_next_state = c_LEFT;
      c_LEFT:  if (w_enter_right) w_next_state = c_RIGHT;
      c_RIGHT: if (w_enter_left)  w_next_state = c_LEFT;
      default: w_next_state = c_SYNC;
    endcase
  end

  always_comb begin
    w_check_left = 1'b0;
    w_pair_ok    = 1'b0;
    w_pair_err   = 1'b0;
    case (r_state)
      c_LEFT:  w_check_left = w_enter_right;
      c_RIGHT: begin
        if (w_enter_left) begin
          if (r_left_err || w_len_bad)
            w_pair_err = 1'b1;
          else
            w_pair_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The left word is snapshotted one bclk into the right slot, after the
  // trailing I2S bit has landed and before the next left slot overwrites it.
  always_ff @(posedge bclk) begin
    if (reset) begin
      r_left_err      <= 1'b0;
      r_pend_ok       <= 1'b0;
      r_pend_err      <= 1'b0;
      r_enter_right_d <= 1'b0;
      r_left_hold     <= '0;
    end else begin
      if (w_check_left)
        r_left_err <= w_len_bad;
      r_pend_ok       <= w_pair_ok;
      r_pend_err      <= w_pair_err;
      r_enter_right_d <= w_enter_right;
      if (r_enter_right_d)
        r_left_hold <= r_left_sr;
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      o_left      <= '0;
      o_right     <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= r_pend_ok;
      o_frame_err <= r_pend_err;
      if (r_pend_ok) begin
        o_left  <= r_left_hold;
        o_right <= r_right_sr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2s_stereo_rx
// Purpose  : Self-checking bench; instance A is I2S 24/32, instance B is
//            left-justified 16/16. Expected strobes are queued per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_stereo_rx;

  typedef struct {
    bit          err;
    logic [23:0] l;
    logic [23:0] r;
    longint      cyc;
  } ev_t;

  logic        bclk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        lr_a = 1'b0, sd_a = 1'b0, lr_b = 1'b0, sd_b = 1'b0;
  logic [23:0] o_left_a, o_right_a;
  logic [15:0] o_left_b, o_right_b;
  logic        o_valid_a, o_frame_err_a, o_valid_b, o_frame_err_b;

  ev_t         q_a[$];
  ev_t         q_b[$];
  ev_t         ea, eb;
  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;
  bit          carry[2];
  bit          pend[2];
  bit          perr[2];
  logic [23:0] pl[2], pr[2], good_l[2], good_r[2];

  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  i2s_stereo_rx #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .MODE(0), .LEFT_LEVEL(1'b0)) u_dut_a (
    .bclk(bclk), .reset(rst_a), .lrclk(lr_a), .sdata_in(sd_a),
    .o_left(o_left_a), .o_right(o_right_a), .o_valid(o_valid_a), .o_frame_err(o_frame_err_a)
  );

  i2s_stereo_rx #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .MODE(1), .LEFT_LEVEL(1'b0)) u_dut_b (
    .bclk(bclk), .reset(rst_b), .lrclk(lr_b), .sdata_in(sd_b),
    .o_left(o_left_b), .o_right(o_right_b), .o_valid(o_valid_b), .o_frame_err(o_frame_err_b)
  );

  always @(posedge bclk) begin
    #1;
    if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
      n_checks++; n_fail++;
      ea = q_a.pop_front();
      $display("FAIL strobe_a missed: required err=%b at cycle %0d, no strobe observed", ea.err, ea.cyc);
    end
    if (o_valid_a || o_frame_err_a) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_a unexpected: valid=%b err=%b at cycle %0d, required none",
                 o_valid_a, o_frame_err_a, cyc);
      end else begin
        ea = q_a.pop_front();
        if (o_valid_a !== !ea.err || o_frame_err_a !== ea.err || o_left_a !== ea.l ||
            o_right_a !== ea.r || ea.cyc != cyc) begin
          n_fail++;
          $display("FAIL strobe_a: got valid=%b err=%b L=%h R=%h cyc=%0d, required err=%b L=%h R=%h cyc=%0d",
                   o_valid_a, o_frame_err_a, o_left_a, o_right_a, cyc, ea.err, ea.l, ea.r, ea.cyc);
        end
      end
    end
  end

  always @(posedge bclk) begin
    #1;
    if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
      n_checks++; n_fail++;
      eb = q_b.pop_front();
      $display("FAIL strobe_b missed: required err=%b at cycle %0d, no strobe observed", eb.err, eb.cyc);
    end
    if (o_valid_b || o_frame_err_b) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_b unexpected: valid=%b err=%b at cycle %0d, required none",
                 o_valid_b, o_frame_err_b, cyc);
      end else begin
        eb = q_b.pop_front();
        if (o_valid_b !== !eb.err || o_frame_err_b !== eb.err || o_left_b !== eb.l[15:0] ||
            o_right_b !== eb.r[15:0] || eb.cyc != cyc) begin
          n_fail++;
          $display("FAIL strobe_b: got valid=%b err=%b L=%h R=%h cyc=%0d, required err=%b L=%h R=%h cyc=%0d",
                   o_valid_b, o_frame_err_b, o_left_b, o_right_b, cyc, eb.err, eb.l[15:0], eb.r[15:0], eb.cyc);
        end
      end
    end
  end

  function automatic bit bit_of(input logic [23:0] d, input int dw, input int k);
    if (k < dw) return d[dw-1-k];
    return 1'($urandom_range(0, 1));
  endfunction

  // The pair armed by the previous frame completes at this left edge;
  // the strobe appears one bclk after the edge.
  task automatic push_pending(input int sel);
    ev_t e;
    if (!pend[sel]) return;
    e.err = perr[sel];
    if (perr[sel]) begin
      e.l = good_l[sel]; e.r = good_r[sel];
    end else begin
      e.l = pl[sel]; e.r = pr[sel];
      good_l[sel] = pl[sel]; good_r[sel] = pr[sel];
    end
    e.cyc = cyc + 2;
    if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
    pend[sel] = 1'b0;
  endtask

  task automatic drive_slot(input int sel, input bit lvl, input logic [23:0] data, input int len);
    int dw = (sel == 0) ? 24 : 16;
    for (int i = 0; i < len; i++) begin
      @(negedge bclk);
      if (i == 0 && lvl == 1'b0) push_pending(sel);
      if (sel == 0) begin
        lr_a = lvl;
        sd_a = (i == 0) ? carry[0] : bit_of(data, dw, i - 1);
      end else begin
        lr_b = lvl;
        sd_b = bit_of(data, dw, i);
      end
    end
    if (sel == 0) carry[0] = bit_of(data, dw, len - 1);
  endtask

  task automatic drive_frame(input int sel, input logic [23:0] l, input logic [23:0] r,
                             input int llen, input int rlen, input bit chk);
    int sw = (sel == 0) ? 32 : 16;
    drive_slot(sel, 1'b0, l, llen);
    drive_slot(sel, 1'b1, r, rlen);
    if (chk) begin
      pend[sel] = 1'b1;
      perr[sel] = (llen != sw) || (rlen != sw);
      pl[sel]   = l;
      pr[sel]   = r;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge bclk);
    n_checks++;
    if (o_left_a !== 24'h0 || o_right_a !== 24'h0 || o_valid_a !== 1'b0 || o_frame_err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: got L=%h R=%h v=%b e=%b, required all zero",
               o_left_a, o_right_a, o_valid_a, o_frame_err_a);
    end
    n_checks++;
    if (o_left_b !== 16'h0 || o_right_b !== 16'h0 || o_valid_b !== 1'b0 || o_frame_err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: got L=%h R=%h v=%b e=%b, required all zero",
               o_left_b, o_right_b, o_valid_b, o_frame_err_b);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic test_i2s_basic;
    drive_slot(0, 1'b1, 24'h0, 20);
    repeat (4) drive_frame(0, 24'hA5A5A5, 24'h5A5A5A, 32, 32, 1'b1);
  endtask

  task automatic test_frame_err;
    drive_frame(0, 24'h123456, 24'h654321, 32, 32, 1'b1);
    drive_frame(0, 24'hDEAD01, 24'hBEEF02, 32, 31, 1'b1);
    drive_frame(0, 24'h0F0F0F, 24'hF0F0F0, 32, 32, 1'b1);
  endtask

  task automatic test_reset_mid;
    drive_frame(0, 24'hC3C3C3, 24'h3C3C3C, 32, 32, 1'b1);
    drive_frame(0, 24'h777777, 24'h888888, 32, 32, 1'b1);
    fork
      drive_frame(0, 24'h111111, 24'h222222, 32, 32, 1'b0);
      begin
        repeat (6) @(negedge bclk);
        rst_a = 1'b1;
        pend[0] = 1'b0;
        @(negedge bclk);
        n_checks++;
        if (o_left_a !== 24'h0 || o_right_a !== 24'h0 || o_valid_a !== 1'b0 || o_frame_err_a !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid: got L=%h R=%h v=%b e=%b, required all zero",
                   o_left_a, o_right_a, o_valid_a, o_frame_err_a);
        end
        good_l[0] = 24'h0;
        good_r[0] = 24'h0;
        @(negedge bclk);
        rst_a = 1'b0;
      end
    join
    drive_frame(0, 24'h345678, 24'h876543, 32, 32, 1'b1);
    drive_frame(0, 24'hABCDEF, 24'hFEDCBA, 32, 32, 1'b1);
  endtask

  task automatic test_release_mid_right;
    rst_a = 1'b1;
    pend[0] = 1'b0;
    good_l[0] = 24'h0;
    good_r[0] = 24'h0;
    fork
      drive_frame(0, 24'h999999, 24'hAAAAAA, 32, 32, 1'b0);
      begin
        repeat (42) @(negedge bclk);
        rst_a = 1'b0;
      end
    join
    drive_frame(0, 24'h13579B, 24'h2468AC, 32, 32, 1'b1);
    drive_frame(0, 24'hFFFFFF, 24'h000001, 32, 32, 1'b1);
  endtask

  task automatic test_stall;
    drive_frame(0, 24'h5555AA, 24'hAA5555, 32, 232, 1'b1);
    drive_frame(0, 24'h800001, 24'h7FFFFE, 32, 32, 1'b1);
    drive_frame(0, 24'h0000FF, 24'hFF0000, 32, 32, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++)
      drive_frame(0, 24'($urandom), 24'($urandom), 32, 32, 1'b1);
    drive_slot(0, 1'b0, 24'h0, 32);
  endtask

  task automatic test_left_justified;
    drive_slot(1, 1'b1, 24'h0, 7);
    repeat (3) drive_frame(1, 24'h008001, 24'h007FFE, 16, 16, 1'b1);
    drive_frame(1, 24'h00C0DE, 24'h00FACE, 16, 16, 1'b1);
    drive_frame(1, 24'h008001, 24'h007FFE, 16, 16, 1'b1);
    drive_slot(1, 1'b0, 24'h0, 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i2s_basic();
    test_frame_err();
    test_reset_mid();
    test_release_mid_right();
    test_stall();
    test_back_to_back();
    test_left_justified();
    repeat (4) @(negedge bclk);
    while (q_a.size() > 0) begin
      n_checks++; n_fail++;
      ea = q_a.pop_front();
      $display("FAIL strobe_a pending at end: required err=%b at cycle %0d", ea.err, ea.cyc);
    end
    while (q_b.size() > 0) begin
      n_checks++; n_fail++;
      eb = q_b.pop_front();
      $display("FAIL strobe_b pending at end: required err=%b at cycle %0d", eb.err, eb.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
